// File: rtl/bram_port_master.sv
// bram_port_master: request-side controller for one port of a read-first
// true-dual-port block RAM. It drives the RAM port from a valid/ready request
// stream, absorbs the RAM's one-cycle read latency, and returns one in-order
// response per request through a 3-entry buffer.
//
// Ports:
//   clk, rst                     single clock, synchronous active-high reset
//   req_valid/req_ready          request handshake (fire = valid && ready)
//   req_we, req_addr, req_data   request payload (write enable, address, data)
//   resp_valid/resp_ready        response handshake (pop = valid && ready)
//   resp_data                    read data, or the pre-write word for writes
//   mem_en, mem_we, mem_addr,
//   mem_di                       RAM port drive
//   mem_do                       RAM read data, valid the cycle after mem_en
module bram_port_master #(
    parameter int unsigned SIZE  = 1024,
    parameter int unsigned WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [$clog2(SIZE)-1:0] req_addr,
    input  logic [WIDTH-1:0]        req_data,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [WIDTH-1:0]        resp_data,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [$clog2(SIZE)-1:0] mem_addr,
    output logic [WIDTH-1:0]        mem_di,
    input  logic [WIDTH-1:0]        mem_do
);
    localparam int unsigned DEPTH = 3;
    localparam int unsigned PW    = 2;
    localparam int unsigned CW    = 2;
    localparam int unsigned SW    = 3;

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;
    logic             inflight_q;
    logic             oor_q;

    logic fire_c;
    logic in_range_c;
    logic push_c;
    logic pop_c;

    // Circular pointer advance over a non-power-of-two depth.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready depends only on registers (plus reset), so there is no
    // resp_ready -> req_ready path; reserving a slot for the in-flight
    // read guarantees a capture never overflows the buffer.
    assign req_ready  = !rst && ((SW'(count_q) + SW'(inflight_q)) < SW'(DEPTH));
    assign fire_c     = req_valid && req_ready;
    assign in_range_c = 32'(req_addr) < SIZE;

    // RAM drive straight from the request stream; out-of-range addresses
    // never touch the RAM.
    assign mem_en   = fire_c && in_range_c;
    assign mem_we   = mem_en && req_we;
    assign mem_addr = req_addr;
    assign mem_di   = req_data;

    // Response side: buffer head is presented directly.
    assign push_c     = inflight_q;
    assign resp_valid = (count_q != '0);
    assign resp_data  = buf_q[head_q];
    assign pop_c      = resp_valid && resp_ready;

    // In-flight tracking, capture of mem_do, and buffer bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            inflight_q <= 1'b0;
            oor_q      <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            inflight_q <= fire_c;
            oor_q      <= !in_range_c;
            if (push_c) begin
                buf_q[tail_q] <= oor_q ? '0 : mem_do;
                tail_q        <= ptr_inc(tail_q);
            end
            if (pop_c) begin
                head_q <= ptr_inc(head_q);
            end
            count_q <= count_q + CW'(push_c) - CW'(pop_c);
        end
    end

endmodule

// File: tb/tb_bram_port_master.sv
module tb_bram_port_master;
    localparam int unsigned SIZE  = 1000;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned AW    = $clog2(SIZE);

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_data;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_di;
    logic [WIDTH-1:0] mem_do = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               pop_cyc_q[$];
    logic [WIDTH-1:0] ram     [1024];
    logic [WIDTH-1:0] ref_mem [1024];
    logic             rand_rr = 1'b0;

    bram_port_master #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_di     (mem_di),
        .mem_do     (mem_do)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-first RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_do <= ram[mem_addr];
            if (mem_we) ram[mem_addr] <= mem_di;
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard on every response handshake, and checks
    // that a stalled response holds steady.
    logic             prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rst && prev_hold) begin
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_data", 32'(resp_data), 32'(prev_data));
        end
        prev_hold = !rst && resp_valid && !resp_ready;
        prev_data = resp_data;
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got 0x%0h expected none (cycle %0d)", resp_data, cyc);
            end else begin
                check("resp_data", 32'(resp_data), 32'(exp_q.pop_front()));
            end
            pop_cyc_q.push_back(cyc);
        end
    end

    // Random response backpressure for the soak phase.
    always @(posedge clk) begin
        if (rand_rr) begin
            #1;
            resp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Present one request and wait (bounded) for it to fire; on fire check
    // the RAM drive and push the expected response.
    task automatic do_req(input logic we, input int unsigned addr, input logic [WIDTH-1:0] data,
                          output int fcyc, output int stalls);
        logic [WIDTH-1:0] e;
        logic             inr;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = AW'(addr);
        req_data  = data;
        stalls    = 0;
        fcyc      = -1;
        inr       = (addr < SIZE);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready) begin
                fcyc = cyc;
                check("mem_en", 32'(mem_en), 32'(inr));
                check("mem_we", 32'(mem_we), 32'(inr && we));
                check("mem_addr", 32'(mem_addr), addr);
                check("mem_di", 32'(mem_di), 32'(data));
                e = inr ? ref_mem[addr] : '0;
                if (inr && we) ref_mem[addr] = data;
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        if (fcyc < 0) begin
            total++;
            bad++;
            $display("FAIL req_timeout: addr %0d not accepted within 200 cycles", addr);
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, f1, f2, f, s, st, t0;
        logic we;
        int unsigned a;

        for (int i = 0; i < 1024; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = AW'(3);
        req_data   = 16'h5555;
        resp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Test 1: read-first, back-to-back write/write/read at A=5
        pop_cyc_q.delete();
        do_req(1'b1, 5, 16'h1234, f0, s);
        do_req(1'b1, 5, 16'hBEEF, f1, s);
        do_req(1'b0, 5, 16'h0000, f2, s);
        idle(5);
        check("t1_fire1", 32'(f1), 32'(f0 + 1));
        check("t1_fire2", 32'(f2), 32'(f0 + 2));
        check("t1_npops", 32'(pop_cyc_q.size()), 32'd3);
        if (pop_cyc_q.size() == 3)
            for (int i = 0; i < 3; i++) check("t1_lat", 32'(pop_cyc_q[i]), 32'(f0 + 2 + i));

        // Test 2: preload then stream 16 reads
        for (int i = 0; i < 16; i++) do_req(1'b1, i, WIDTH'(16'h0100 + i), f, s);
        idle(4);
        pop_cyc_q.delete();
        st = 0;
        for (int i = 0; i < 16; i++) begin
            do_req(1'b0, i, 16'h0000, f, s);
            if (i == 0) f0 = f;
            st += s;
        end
        idle(4);
        check("t2_stalls", 32'(st), 32'd0);
        check("t2_npops", 32'(pop_cyc_q.size()), 32'd16);
        if (pop_cyc_q.size() == 16)
            for (int i = 0; i < 16; i++) check("t2_stream", 32'(pop_cyc_q[i]), 32'(f0 + 2 + i));

        // Test 3: backpressure, 3 accepted then stall
        resp_ready = 1'b0;
        st = 0;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, i, 16'h0000, f, s);
            st += s;
        end
        check("t3_stalls", 32'(st), 32'd0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = AW'(3);
        repeat (4) begin
            @(negedge clk);
            check("t3_ready_low", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("t3_head_valid", 32'(resp_valid), 32'd1);
        check("t3_head_data", 32'(resp_data), 32'h0100);
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        do_req(1'b0, 3, 16'h0000, f, s);
        idle(5);
        check("t3_drained", 32'(exp_q.size()), 32'd0);

        // Test 4: one pop while full, then refill to full
        resp_ready = 1'b0;
        for (int i = 4; i < 7; i++) do_req(1'b0, i, 16'h0000, f, s);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = AW'(7);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("t4_full_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        do_req(1'b0, 7, 16'h0000, f, s);
        req_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("t4_refull_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b1;
        idle(5);
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // Test 5: reset with a read in flight
        do_req(1'b0, 7, 16'h0000, f, s);
        rst       = 1'b1;
        req_valid = 1'b1;
        req_addr  = AW'(9);
        @(negedge clk);
        check("t5_rst_ready", 32'(req_ready), 32'd0);
        check("t5_rst_mem_en", 32'(mem_en), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        repeat (4) begin
            @(negedge clk);
            check("t5_no_resp", 32'(resp_valid), 32'd0);
            check("t5_resp_data", 32'(resp_data), 32'd0);
            check("t5_ready", 32'(req_ready), 32'd1);
            @(posedge clk);
            #1;
        end

        // Test 6: out-of-range read and write
        pop_cyc_q.delete();
        do_req(1'b0, 1000, 16'h0000, f0, s);
        idle(4);
        check("t6_npops", 32'(pop_cyc_q.size()), 32'd1);
        if (pop_cyc_q.size() == 1) check("t6_lat", 32'(pop_cyc_q[0]), 32'(f0 + 2));
        do_req(1'b1, 1010, 16'hDEAD, f, s);
        do_req(1'b0, 1010, 16'h0000, f, s);
        idle(4);

        // Random mixed soak with random backpressure
        rand_rr = 1'b1;
        t0 = cyc;
        while (cyc < t0 + 10000) begin
            we = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 9) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 31);
            do_req(we, a, WIDTH'($urandom), f, s);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        req_valid = 1'b0;
        rand_rr   = 1'b0;
        @(posedge clk);
        #2;
        resp_ready = 1'b1;
        idle(8);
        check("soak_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_port_master.md
Name: bram_port_master

Overview:
- Request-side controller for one port of the team's true-dual-port read-first block RAM.
- Accepts a valid/ready request stream (read or write), drives the RAM port signals (en, we, addr, di), and absorbs the RAM's one-cycle read latency.
- Returns one response per request, in order, on a valid/ready response stream, via a 3-entry buffer.
- Gives full throughput with no combinational path from resp_ready to req_ready. HIR-generated datapaths instantiate one per RAM port.

Parameters:
SIZE, 1024, RAM depth in words; address width is $clog2(SIZE)
WIDTH, 16, data word width in bits

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready (fire)
req_we  in  1  1 = write, 0 = read
req_addr  in  $clog2(SIZE)  word address
req_data  in  WIDTH  write data; ignored for reads
resp_valid  out  1  response present
resp_ready  in  1  response consumed when resp_valid && resp_ready (pop)
resp_data  out  WIDTH  read data; for writes, the old word at the address (read-first)
mem_en  out  1  RAM port enable
mem_we  out  1  RAM port write enable
mem_addr  out  $clog2(SIZE)  RAM port address
mem_di  out  WIDTH  RAM port write data
mem_do  in  WIDTH  RAM port read data, valid the cycle after mem_en

Behaviour:
- Reset (rst=1 sampled at posedge):
  - clears buffer count, head/tail pointers, all buffer entries to 0, and the in-flight flag.
  - While rst=1: req_ready=0, mem_en=0, mem_we=0; resp_valid=0 and resp_data=0 from the following cycle.
- Single clock; all state registered on posedge clk.
- RAM drive is combinational from the request stream:
  - mem_addr=req_addr, mem_di=req_data.
  - mem_en = fire && (req_addr < SIZE).
  - mem_we = mem_en && req_we.
- In-flight flag: inflight <= fire. An out-of-range fire also sets it, with a tag bit oor <= (req_addr >= SIZE).
- Capture: when inflight=1, push mem_do (or 0 if oor=1) into the buffer tail that cycle.
- Buffer: 3 entries, FIFO order; count in 0..3.
  - resp_valid = (count != 0); resp_data = head entry.
- Each cycle, count updates by +push −pop. Simultaneous push and pop is allowed at any count, including count=3 with pop.
- req_ready = !rst && (count + inflight < 3).
  - Depends on registers only, so no resp_ready→req_ready path.
  - Guarantees a push never overflows.
- Latency: fire at cycle T → mem_do sampled at T+1 → resp_valid at T+2 at the earliest.
- Throughput: with resp_ready held 1, one request per cycle indefinitely (steady state count=1, inflight=1).
- Write responses always carry the pre-write word (RAM is read-first). Back-to-back write-then-read at the same address returns the new word on the read.
- Backpressure: with resp_ready=0, at most 3 requests are accepted beyond the last pop; then req_ready=0 until a pop.
- Outputs resp_valid and resp_data are stable while resp_valid=1 and resp_ready=0.
- Reset mid-operation: an in-flight read is discarded and its mem_do on the next cycle is not captured. Buffered responses are lost. RAM contents are untouched.
- No error signalling. An out-of-range address yields response 0 with no RAM access.

Test Plan:
1. Read-first check, SIZE=1024: write A=5 D=0x1234, write A=5 D=0xBEEF, read A=5, one per cycle, resp_ready=1 → responses at T+2..T+4: (unchecked), 0x1234, 0xBEEF.
2. Streaming: preload A=0..15 with 0x0100+A, then 16 consecutive reads with resp_ready=1 → req_ready never drops; resp_data 0x0100..0x010F on 16 consecutive cycles starting 2 cycles after the first fire.
3. Backpressure: resp_ready=0, req_valid held 1 with reads A=0,1,2,3 → exactly 3 fires, then req_ready=0. Raise resp_ready → 0x0100, 0x0101, 0x0102 in order, then the A=3 read is accepted.
4. Simultaneous push/pop at full: count=3, one cycle of resp_ready=1 → count stays ≤3, no overflow, order preserved (scoreboard).
5. Reset mid-op: fire a read of A=7, assert rst the next cycle for 1 cycle → resp_valid=0 afterwards, no response for A=7, req_ready=1 after rst drops.
6. Out-of-range, SIZE=1000: read A=1000 → mem_en=0 on the fire cycle, response 0x0000 two cycles later. A random mixed stream with random resp_ready across 10k cycles matches the reference-model scoreboard.
